// File: rtl/ctrl_pipe.sv
// ctrl_pipe: DEPTH-stage valid/ready register pipeline carrying a WIDTH-bit
// control word, with synchronous flush and asynchronous active-low reset.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   flush      synchronous kill of every stage (overrides stall and input)
//   in_valid   upstream word present
//   in_ready   stage 0 can accept this cycle (forced low while flushing)
//   in_data    upstream control word
//   out_valid  last stage holds a valid word
//   out_ready  downstream accepts this cycle
//   out_data   last-stage word, all-zero whenever out_valid is low
//   occupancy  number of valid stages (0..DEPTH)
module ctrl_pipe #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];

  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];
  logic             rdy_acc;
  logic [OCC_W-1:0] occ;

  // Readiness ripples from the output back toward stage 0: a stage may load
  // if it is empty or anything downstream of it can move. The running
  // accumulator avoids a self-referencing vector.
  always_comb begin
    rdy     = '0;
    rdy_acc = out_ready;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      rdy_acc           = rdy_acc | ~v_q[DEPTH-1-k];
      rdy[DEPTH-1-k]    = rdy_acc;
    end
  end

  // Source of each stage: stage 0 takes the input port, others the stage before.
  always_comb begin
    src_v    = '0;
    src_v[0] = in_valid;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      src_d[k] = '0;
    end
    src_d[0] = in_data;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      src_v[k] = v_q[k-1];
      src_d[k] = d_q[k-1];
    end
  end

  always_comb begin
    v_d = v_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      d_d[k] = d_q[k];
      if (flush) begin
        v_d[k] = 1'b0;
        d_d[k] = '0;
      end else if (rdy[k]) begin
        v_d[k] = src_v[k];
        // Bubbles carry all-zero control so they never trigger side effects.
        d_d[k] = src_v[k] ? src_d[k] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      occ = occ + OCC_W'(v_q[k]);
    end
  end

  assign occupancy = occ;
  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = v_q[DEPTH-1] ? d_q[DEPTH-1] : '0;

endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;

  localparam int W = 9;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [$clog2(D+1)-1:0] occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  ctrl_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: slot contents, position D-1 is the output.
  logic         m_v [D];
  logic [W-1:0] m_d [D];
  initial for (int i = 0; i < D; i++) begin m_v[i] = 1'b0; m_d[i] = '0; end

  // On each edge everything at or below the furthest point that can move
  // shifts one slot toward the output; anything beyond it stays put.
  always @(posedge clk or negedge rst) begin : model
    int b;
    if (!rst || flush) begin
      for (int i = 0; i < D; i++) begin m_v[i] <= 1'b0; m_d[i] <= '0; end
    end else begin
      if (out_ready) b = D - 1;
      else begin
        b = -1;
        for (int i = 0; i < D; i++) if (!m_v[i]) b = i;
      end
      for (int i = 1; i < D; i++)
        if (i <= b) begin m_v[i] <= m_v[i-1]; m_d[i] <= m_d[i-1]; end
      if (b >= 0) begin
        m_v[0] <= in_valid;
        m_d[0] <= in_valid ? in_data : '0;
      end
    end
  end

  function automatic int m_occ();
    int c = 0;
    for (int i = 0; i < D; i++) c += int'(m_v[i]);
    return c;
  endfunction

  function automatic logic m_in_ready();
    logic r = out_ready;
    for (int i = 0; i < D; i++) if (!m_v[i]) r = 1'b1;
    return r & ~flush;
  endfunction

  // Order scoreboard, independent of slot positions.
  logic [W-1:0] sb [$];
  always @(negedge rst) sb.delete();

  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(m_v[D-1]));
    chk("out_data", 32'(out_data), m_v[D-1] ? 32'(m_d[D-1]) : 32'h0);
    chk("occupancy", 32'(occupancy), 32'(m_occ()));
    chk("in_ready", 32'(in_ready), 32'(m_in_ready()));
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_order: got %0h expected nothing at %0t", out_data, $time);
      end else begin
        chk("sb_order", 32'(out_data), 32'(sb.pop_front()));
      end
    end
    if (flush) sb.delete();
    if (rst && in_valid && in_ready) sb.push_back(in_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
  endtask

  initial begin
    step(); step();
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst = 1'b1;
    step();

    // Streaming
    drive(1, 9'h1A5, 1); step();
    drive(1, 9'h0F3, 1); step();
    chk("str_data0", 32'(out_data), 32'h1A5);
    chk("str_model0", 32'(m_d[D-1]), 32'h1A5);
    chk("str_occ0", 32'(occupancy), 2);
    drive(1, 9'h100, 1); step();
    chk("str_data1", 32'(out_data), 32'h0F3);
    chk("str_occ1", 32'(occupancy), 2);
    drive(0, 0, 1); step();
    chk("str_data2", 32'(out_data), 32'h100);
    chk("str_valid2", 32'(out_valid), 1);
    step(); step();

    // Backpressure
    drive(1, 9'h011, 1); step();
    drive(1, 9'h022, 1); step();
    drive(1, 9'h033, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_data", 32'(out_data), 32'h011);
      chk("bp_occ", 32'(occupancy), 2);
      step();
    end
    drive(0, 0, 1); step();
    chk("bp_rel0", 32'(out_data), 32'h022);
    chk("bp_model", 32'(m_d[D-1]), 32'h022);
    step();
    chk("bp_rel1", 32'(out_valid), 0);

    // Bubble
    drive(1, 9'h055, 1); step();
    drive(0, 0, 1); step();
    chk("bub_a", 32'(out_data), 32'h055);
    drive(1, 9'h0AA, 1); step();
    chk("bub_valid", 32'(out_valid), 0);
    chk("bub_data", 32'(out_data), 0);
    drive(0, 0, 1); step();
    chk("bub_b", 32'(out_data), 32'h0AA);
    step();

    // Flush
    drive(1, 9'h1FF, 1); step();
    drive(1, 9'h003, 1); step();
    drive(1, 9'h077, 0); flush = 1'b1;
    #1 chk("fl_in_ready", 32'(in_ready), 0);
    step();
    flush = 1'b0;
    chk("fl_occ", 32'(occupancy), 0);
    chk("fl_valid", 32'(out_valid), 0);
    chk("fl_data", 32'(out_data), 0);
    drive(0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_never", 32'(out_valid), 0);
    end

    // Asynchronous reset mid-stream
    drive(1, 9'h0D1, 0); step();
    drive(1, 9'h0D2, 0); step();
    chk("ar_full", 32'(occupancy), 2);
    drive(1, 9'h0EE, 0);
    #2 rst = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_data", 32'(out_data), 0);
    chk("ar_occ", 32'(occupancy), 0);
    chk("ar_in_ready", 32'(in_ready), 1);
    step();
    chk("ar_nocap", 32'(occupancy), 0);
    #1 rst = 1'b1;
    drive(1, 9'h0C3, 1); step();
    drive(0, 0, 1); step();
    chk("ar_post_valid", 32'(out_valid), 1);
    chk("ar_post_data", 32'(out_data), 32'h0C3);
    step();

    // Full throughput
    drive(1, 9'h001, 0); step();
    drive(1, 9'h002, 0); step();
    for (int k = 0; k < 10; k++) begin
      drive((k + 3) <= 10, W'(k + 3), 1);
      #1;
      chk("ft_valid", 32'(out_valid), 1);
      chk("ft_data", 32'(out_data), 32'(k + 1));
      chk("ft_in_ready", 32'(in_ready), 1);
      step();
    end
    drive(0, 0, 1); step(); step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 149) == 0) begin
        #1 rst = 1'b0;
        #2 rst = 1'b1;
      end
      step();
    end

    flush = 1'b0;
    drive(0, 0, 1);
    repeat (D + 2) step();
    chk("end_sb_empty", 32'(sb.size()), 0);
    chk("end_occ", 32'(occupancy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
